// File: rtl/instr_encoder_writer.sv
// Packs MIPS instruction fields into 32-bit words, buffers them in a small FIFO,
// and streams them to the instruction-memory load port at sequential addresses.
module instr_encoder_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_WORDS = 4096,
    localparam int unsigned CNT_W    = $clog2(MAX_WORDS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       fmt,
    input  logic [5:0]       op,
    input  logic [4:0]       rsad,
    input  logic [4:0]       rtad,
    input  logic [4:0]       rdad,
    input  logic [4:0]       shamt,
    input  logic [5:0]       func,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic [31:0]      raw,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    input  logic             wr_ack,
    output logic [CNT_W-1:0] words_written,
    output logic             im_full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    function automatic logic [31:0] pack_word(
        input logic [1:0]  f_fmt,
        input logic [5:0]  f_op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_sh,
        input logic [5:0]  f_func,
        input logic [15:0] f_imm16,
        input logic [25:0] f_imm26,
        input logic [31:0] f_raw
    );
        logic [31:0] word;
        case (f_fmt)
            2'd0:    word = {f_op, f_rs, f_rt, f_rd, f_sh, f_func};
            2'd1:    word = {f_op, f_rs, f_rt, f_imm16};
            2'd2:    word = {f_op, f_imm26};
            default: word = f_raw;
        endcase
        return word;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = PTR_W'(0);
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_count;
    logic             r_im_full;

    logic             w_push;
    logic             w_pop;
    logic             w_in_ready;
    logic             w_nonempty;
    logic [31:0]      w_total;
    logic [31:0]      w_packed;

    // Admission control: budget counts both written and still-buffered words.
    always_comb begin
        w_nonempty = (r_occ != OCC_W'(0));
        w_total    = 32'(r_count) + 32'(r_occ);
        w_in_ready = (r_occ != OCC_W'(DEPTH)) && (w_total < 32'(MAX_WORDS)) && !r_im_full;
        w_push     = in_valid && w_in_ready;
        w_pop      = w_nonempty && wr_ack;
        w_packed   = pack_word(fmt, op, rsad, rtad, rdad, shamt, func, imm16, imm26, raw);
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_packed;
        end
    end

    // Pointers, occupancy, write address, acknowledged-word count and limit flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= PTR_W'(0);
            r_rd_ptr  <= PTR_W'(0);
            r_occ     <= OCC_W'(0);
            r_addr    <= BASE_ADDR;
            r_count   <= CNT_W'(0);
            r_im_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr  <= next_ptr(r_rd_ptr);
                r_addr    <= r_addr + 32'd4;
                r_count   <= r_count + CNT_W'(1);
                r_im_full <= ((32'(r_count) + 32'd1) == 32'(MAX_WORDS));
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign in_ready      = w_in_ready;
    assign wr_en         = w_nonempty;
    assign wr_data       = r_mem[r_rd_ptr];
    assign wr_addr       = r_addr;
    assign words_written = r_count;
    assign im_full       = r_im_full;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Directed scoreboard bench for instr_encoder_writer: writes are checked in order
// against expected (address, word) pairs queued at accept time.
module tb_instr_encoder_writer;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [1:0]  fmt;
    logic [5:0]  op, func;
    logic [4:0]  rsad, rtad, rdad, shamt;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] raw;
    logic        wr_en, wr_ack, im_full;
    logic [31:0] wr_addr, wr_data;
    logic [12:0] words_written;

    logic        l_in_valid, l_in_ready, l_wr_en, l_wr_ack, l_im_full;
    logic [31:0] l_wr_addr, l_wr_data;
    logic [2:0]  l_words_written;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] sb [$];
    logic [31:0] exp_addr;
    bit          toggle;
    logic [63:0] held;
    bit          hold_v = 1'b0;

    instr_encoder_writer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .rsad(rsad), .rtad(rtad), .rdad(rdad), .shamt(shamt),
        .func(func), .imm16(imm16), .imm26(imm26), .raw(raw),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .words_written(words_written), .im_full(im_full)
    );

    instr_encoder_writer #(.MAX_WORDS(3)) dut_lim (
        .clk(clk), .reset(reset), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .fmt(fmt), .op(op), .rsad(rsad), .rtad(rtad), .rdad(rdad), .shamt(shamt),
        .func(func), .imm16(imm16), .imm26(imm26), .raw(raw),
        .wr_en(l_wr_en), .wr_addr(l_wr_addr), .wr_data(l_wr_data), .wr_ack(l_wr_ack),
        .words_written(l_words_written), .im_full(l_im_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle) wr_ack = ~wr_ack;
    endtask

    // Offer the currently set fields until accepted; queue the expected write.
    task automatic push_word(input logic [31:0] w);
        int budget = 200;
        bit done   = 1'b0;
        in_valid = 1'b1;
        while (!done && budget > 0) begin
            if (in_ready) done = 1'b1;
            else budget--;
            tick();
        end
        in_valid = 1'b0;
        check("accept_in_time", {31'd0, done}, 32'd1);
        if (done) begin
            sb.push_back({exp_addr, w});
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    task automatic wait_idle();
        int budget = 200;
        while (wr_en && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_wr_en", {31'd0, wr_en}, 32'd0);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        sb.delete();
        exp_addr = BASE;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", wr_addr, BASE);
        check("rst_words", 32'(words_written), 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_im_full", {31'd0, im_full}, 32'd0);
        reset = 1'b0;
    endtask

    // Write monitor: in-order scoreboard compare plus hold-stability under stall.
    always @(negedge clk) begin
        if (reset) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v && wr_en) begin
                check("hold_addr", wr_addr, held[63:32]);
                check("hold_data", wr_data, held[31:0]);
            end
            if (wr_en && wr_ack) begin
                check("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
                if (sb.size() != 0) begin
                    check("wr_addr", wr_addr, sb[0][63:32]);
                    check("wr_data", wr_data, sb[0][31:0]);
                    void'(sb.pop_front());
                end
            end
            hold_v <= wr_en && !wr_ack;
            held   <= {wr_addr, wr_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int offered;
        bit rdy;
        reset = 1'b1; in_valid = 1'b0; l_in_valid = 1'b0;
        fmt = 2'd0; op = 6'd0; rsad = 5'd0; rtad = 5'd0; rdad = 5'd0; shamt = 5'd0;
        func = 6'd0; imm16 = 16'd0; imm26 = 26'd0; raw = 32'd0;
        wr_ack = 1'b0; l_wr_ack = 1'b1; toggle = 1'b0; exp_addr = BASE;
        tick();
        do_reset();
        check("lim_rst_ready", {31'd0, l_in_ready}, 32'd1);
        check("lim_rst_full", {31'd0, l_im_full}, 32'd0);

        // R-format addu with one-cycle latency
        wr_ack = 1'b1;
        fmt = 2'd0; op = 6'd0; rsad = 5'd1; rtad = 5'd2; rdad = 5'd3; shamt = 5'd0; func = 6'h21;
        push_word(32'h0022_1821);
        check("lat_wr_en", {31'd0, wr_en}, 32'd1);
        check("lat_wr_addr", wr_addr, 32'h0000_3000);
        check("lat_wr_data", wr_data, 32'h0022_1821);
        tick();
        check("addu_words", 32'(words_written), 32'd1);

        // I then J back-to-back
        fmt = 2'd1; op = 6'h0D; rsad = 5'd0; rtad = 5'd1; imm16 = 16'h1234;
        push_word(32'h3401_1234);
        fmt = 2'd2; op = 6'h02; imm26 = 26'h000_0C03;
        push_word(32'h0800_0C03);
        wait_idle();
        check("ij_words", 32'(words_written), 32'd3);

        // Backpressure: FIFO fills, head held stable
        do_reset();
        wr_ack = 1'b0; fmt = 2'd3;
        for (int i = 0; i < 4; i++) begin
            raw = 32'hA0 + 32'(i);
            push_word(raw);
        end
        check("bp_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_head_data", wr_data, 32'h0000_00A0);
        check("bp_head_addr", wr_addr, 32'h0000_3000);
        raw = 32'hA4; in_valid = 1'b1;
        tick(); tick(); tick();
        check("bp_ready_still_low", {31'd0, in_ready}, 32'd0);
        wr_ack = 1'b1;
        push_word(32'h0000_00A4);
        wait_idle();
        check("bp_words", 32'(words_written), 32'd5);

        // Pointer wrap with wr_ack toggling every cycle
        do_reset();
        wr_ack = 1'b0; toggle = 1'b1;
        for (int i = 0; i < 10; i++) begin
            raw = 32'hB0 + 32'(i);
            push_word(raw);
        end
        wait_idle();
        toggle = 1'b0; wr_ack = 1'b1;
        check("wrap_words", 32'(words_written), 32'd10);
        check("wrap_next_addr", wr_addr, 32'h0000_3028);

        // Reset mid-stream discards buffered words
        wr_ack = 1'b0;
        do_reset();
        raw = 32'hC0; push_word(raw);
        raw = 32'hC1; push_word(raw);
        check("mid_wr_en", {31'd0, wr_en}, 32'd1);
        do_reset();
        raw = 32'hC2; wr_ack = 1'b1;
        push_word(raw);
        wait_idle();
        check("mid_words", 32'(words_written), 32'd1);

        // Word limit on the MAX_WORDS=3 instance
        acc = 0; offered = 0; fmt = 2'd3;
        for (int c = 0; c < 12; c++) begin
            l_in_valid = (offered < 5);
            raw = 32'hD0 + 32'(offered);
            rdy = l_in_ready;
            tick();
            if (l_in_valid && rdy) acc++;
            if (l_in_valid) offered++;
        end
        l_in_valid = 1'b0;
        check("lim_accepted", 32'(acc), 32'd3);
        check("lim_words", 32'(l_words_written), 32'd3);
        check("lim_im_full", {31'd0, l_im_full}, 32'd1);
        check("lim_ready_low", {31'd0, l_in_ready}, 32'd0);
        check("lim_wr_en_low", {31'd0, l_wr_en}, 32'd0);
        l_in_valid = 1'b1;
        tick(); tick();
        l_in_valid = 1'b0;
        check("lim_ready_stays_low", {31'd0, l_in_ready}, 32'd0);
        check("lim_words_stay", 32'(l_words_written), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
